// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame states, command-byte layout and bit-count helper.
// Imported by both the responder and the initiator-side FSM.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } spi_state_e;

    localparam logic        RW_READ    = 1'b1;
    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned RW_BIT     = 7;

    function automatic logic is_last_bit(input logic [2:0] cnt);
        return cnt == 3'(FRAME_BITS - 1);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous pin followed by a one-flop edge detector.
// RESET_VAL sets the idle level of the pin so that reset release produces no false edge.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversampled two-byte frames (R/W+address, data) that write
// or read back a 2^ADDR_W x 8 register file.
module spi_responder
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SCLK,
    input  logic CS,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_OE
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (SCLK),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (CS),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (MOSI),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    spi_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        shifted;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic              tx_load_q, tx_load_d;
    logic              miso_q, miso_d;
    logic              mem_wr_en;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        tx_load_d = tx_load_q;
        miso_d    = miso_q;
        mem_wr_en = 1'b0;
        shifted   = {shift_q[6:0], mosi_lvl};

        // CS release outranks any SCLK edge seen in the same cycle
        if (cs_rise) begin
            state_d   = IDLE;
            cnt_d     = '0;
            shift_d   = '0;
            tx_load_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (cs_fall) begin
                        state_d = CMD;
                        shift_d = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (is_last_bit(cnt_q)) begin
                            rw_d      = shifted[RW_BIT];
                            addr_d    = shifted[ADDR_W-1:0];
                            tx_load_d = (shifted[RW_BIT] == RW_READ);
                            state_d   = (shifted[RW_BIT] == RW_READ) ? RDATA : WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (is_last_bit(cnt_q)) begin
                            mem_wr_en = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    // The load always lands well before the first detected fall
                    if (tx_load_q) begin
                        tx_d      = mem_q[addr_q];
                        tx_load_d = 1'b0;
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (is_last_bit(cnt_q)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d != RDATA) begin
            miso_d = 1'b0;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (mem_wr_en) begin
            mem_d[addr_q] = shifted;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            tx_q      <= '0;
            tx_load_q <= 1'b0;
            miso_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            tx_load_q <= tx_load_d;
            miso_q    <= miso_d;
            mem_q     <= mem_d;
        end
    end

    assign MISO_OE = ~cs_lvl;
    assign MISO    = miso_q & ~cs_lvl;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: table of write/read-back frames plus
// hand-written abort, over-clock and mid-frame reset sequences.
module tb_spi_responder;

    logic CLK = 1'b0;
    logic RST_N, SCLK, CS, MOSI;
    logic MISO, MISO_OE;

    always #5 CLK = ~CLK;

    spi_responder #(.ADDR_W(7), .SYNC_STAGES(2)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SCLK    (SCLK),
        .CS      (CS),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_OE (MISO_OE)
    );

    typedef struct {
        logic [6:0] addr;
        logic [7:0] wdata;
        int         half;
        logic [7:0] exp_rd;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         half   = 6;
    logic [7:0] frm_rd;
    logic       frm_oe_ok;
    logic       frm_zero_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic cs_low();
        CS = 1'b0;
        tick(half);
    endtask

    task automatic cs_high();
        tick(half);
        CS   = 1'b1;
        MOSI = 1'b0;
        tick(half + 4);
    endtask

    task automatic xfer(input logic mo, input logic expect_zero, output logic mi);
        MOSI = mo;
        tick(half);
        mi = MISO;
        if (MISO_OE !== 1'b1) frm_oe_ok = 1'b0;
        if (expect_zero && MISO !== 1'b0) frm_zero_ok = 1'b0;
        SCLK = 1'b1;
        tick(half);
        SCLK = 1'b0;
    endtask

    task automatic frame_start(input logic rw, input logic [6:0] addr);
        logic [7:0] cmd;
        logic       mi;
        cmd         = {rw, addr};
        frm_rd      = '0;
        frm_oe_ok   = 1'b1;
        frm_zero_ok = 1'b1;
        cs_low();
        for (int i = 7; i >= 0; i--) xfer(cmd[i], 1'b1, mi);
    endtask

    task automatic data_bits(input logic rw, input logic [7:0] wd, input int n);
        logic mi;
        for (int i = 0; i < n; i++) begin
            xfer(wd[7-i], !rw, mi);
            frm_rd = {frm_rd[6:0], mi};
        end
    endtask

    task automatic frame(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                         input int ndata, input int nextra, input logic [7:0] xd);
        logic mi;
        frame_start(rw, addr);
        data_bits(rw, wd, ndata);
        for (int i = 0; i < nextra; i++) xfer(xd[7-i], 1'b1, mi);
        cs_high();
    endtask

    task automatic read_check(input string name, input logic [6:0] addr, input logic [7:0] exp);
        frame(1'b1, addr, 8'h00, 8, 0, 8'h00);
        check({name, "_data"}, 32'(frm_rd), 32'(exp));
        check({name, "_oe"}, 32'(frm_oe_ok), 32'd1);
        check({name, "_cmd_miso0"}, 32'(frm_zero_ok), 32'd1);
    endtask

    task automatic write_check(input string name, input logic [6:0] addr, input logic [7:0] wd);
        frame(1'b0, addr, wd, 8, 0, 8'h00);
        check({name, "_oe"}, 32'(frm_oe_ok), 32'd1);
        check({name, "_miso0"}, 32'(frm_zero_ok), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{addr: 7'h12, wdata: 8'hA5, half: 6, exp_rd: 8'hA5};
        vecs[1] = '{addr: 7'h55, wdata: 8'hC3, half: 4, exp_rd: 8'hC3};
        vecs[2] = '{addr: 7'h00, wdata: 8'h01, half: 5, exp_rd: 8'h01};
        vecs[3] = '{addr: 7'h7F, wdata: 8'h80, half: 6, exp_rd: 8'h80};
        vecs[4] = '{addr: 7'h2A, wdata: 8'h6E, half: 4, exp_rd: 8'h6E};

        RST_N = 1'b0;
        CS    = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        tick(5);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_oe", 32'(MISO_OE), 32'd0);
        RST_N = 1'b1;
        tick(5);
        check("idle_miso", 32'(MISO), 32'd0);
        check("idle_oe", 32'(MISO_OE), 32'd0);

        half = 6;
        read_check("rst_contents_7f", 7'h7F, 8'h00);

        for (int v = 0; v < 5; v++) begin
            half = vecs[v].half;
            write_check($sformatf("vec%0d_wr", v), vecs[v].addr, vecs[v].wdata);
            read_check($sformatf("vec%0d_rd", v), vecs[v].addr, vecs[v].exp_rd);
            check($sformatf("vec%0d_oe_after", v), 32'(MISO_OE), 32'd0);
        end
        half = 6;
        read_check("retain_12", 7'h12, 8'hA5);

        // Aborted write: CS raised after 4 data bits
        write_check("abort_first", 7'h05, 8'h3C);
        frame(1'b0, 7'h05, 8'hFF, 4, 0, 8'h00);
        read_check("abort_rd", 7'h05, 8'h3C);

        // Over-clocked write: 8 extra pulses after the data byte
        frm_zero_ok = 1'b1;
        frame(1'b0, 7'h01, 8'h11, 8, 8, 8'hEE);
        check("overclk_miso0", 32'(frm_zero_ok), 32'd1);
        read_check("overclk_rd", 7'h01, 8'h11);

        // Asynchronous reset in the middle of a read data phase
        write_check("rstmid_wr", 7'h33, 8'hFF);
        frame_start(1'b1, 7'h33);
        data_bits(1'b1, 8'h00, 3);
        tick(4);
        check("rstmid_pre_miso", 32'(MISO), 32'd1);
        check("rstmid_pre_oe", 32'(MISO_OE), 32'd1);
        RST_N = 1'b0;
        #1;
        check("rstmid_miso", 32'(MISO), 32'd0);
        check("rstmid_oe", 32'(MISO_OE), 32'd0);
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        tick(4);
        RST_N = 1'b1;
        tick(half + 4);
        check("rstmid_release_oe", 32'(MISO_OE), 32'd0);
        read_check("rstmid_cleared", 7'h33, 8'h00);
        write_check("rstmid_wr40", 7'h40, 8'h5A);
        read_check("rstmid_rd40", 7'h40, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI responder (peripheral end) that terminates the frames issued by the SPI initiator. It oversamples SCLK, CS and MOSI on the system clock and decodes a two-byte frame: an R/W + address byte, then one data byte. The frame either writes that byte into an internal 128 x 8 register file or returns the stored byte on MISO. It sits at the board-facing edge of the design, opposite the initiator, and is the target used for end-to-end loopback of the SPI path.

## Interface
- ADDR_W, 7: address bits carried in the command byte; register file depth is 2^ADDR_W.
- SYNC_STAGES, 2: synchronizer flops on each of SCLK, CS and MOSI (minimum 2).
- CLK  input  1  system clock. All state changes on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- SCLK  input  1  serial clock from the initiator, asynchronous to CLK.
- CS  input  1  chip select, active low, asynchronous.
- MOSI  input  1  serial data from the initiator.
- MISO  output  1  serial data to the initiator.
- MISO_OE  output  1  MISO output enable for the pad.

## Operation
- SPI mode 0. MOSI is sampled on SCLK rising edges. MISO changes on SCLK falling edges. Bits are sent MSB first.
- Frame layout:
  - Byte 0 bit 7 is R/W (1 = read, 0 = write).
  - Byte 0 bits 6:0 are the address.
  - Byte 1 is the data.
- State machine (state register plus a 3-bit bit counter):
  - IDLE: entered on reset and on CS high. Moves to CMD on the detected CS falling edge. Bit counter is cleared.
  - CMD: shifts in 8 MOSI bits. On the 8th rising edge, latches rw and addr, then moves to WDATA (rw=0) or RDATA (rw=1).
  - WDATA: shifts in 8 bits. On the 8th rising edge, writes mem[addr] <= shifted byte and moves to DONE.
  - RDATA: the tx shift register is loaded with mem[addr] on the CLK after CMD completes. Bit 7 drives MISO from the falling edge that follows the 8th command rising edge. Each later falling edge shifts out the next bit. After the 8th data rising edge, moves to DONE.
  - DONE: all further SCLK edges are ignored, MISO = 0, and no memory access occurs. The block waits for CS high.
- CS high in any state returns the block to IDLE on the next detected CS edge.
  - A partially shifted write is discarded; no memory write occurs.
  - MISO_OE = 0 and MISO = 0 while CS is high.
- MISO_OE = 1 whenever synchronized CS is low. MISO = 0 in CMD and WDATA.
- Register file: 2^ADDR_W x 8 flops. Every location reads 8'h00 after reset. Only a completed WDATA frame writes it.

## Timing
- Input path: SYNC_STAGES synchronizer flops plus one edge-detect flop. An edge on a pin is acted on SYNC_STAGES+1 CLK cycles later (3 with default parameters).
- SCLK high and low phases must each be at least SYNC_STAGES+2 CLK cycles. Faster SCLK is out of specification and its behaviour is undefined.
- Write commit: mem[addr] is updated 1 CLK after the detected 8th WDATA rising edge.
- Read: register file read is combinational, captured into the tx register 1 CLK after the 8th CMD rising edge is detected. This is always earlier than the following detected falling edge.
- MISO update lands SYNC_STAGES+1 CLK after the SCLK falling edge on the pin.
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE, counter = 0, shift and tx registers = 0;
  - MISO = 0, MISO_OE = 0, memory cleared;
  - synchronizer flops reset to SCLK=0, CS=1, MOSI=0 so that no false edge appears after release.
- Simultaneous CS rising and SCLK edge detected in the same CLK: CS wins, and the SCLK edge is ignored.

## Structure
- Shared package spi_pkg holds:
  - the state typedef (IDLE, CMD, WDATA, RDATA, DONE);
  - RW_READ = 1'b1;
  - FRAME_BITS = 8;
  - the bit position of R/W within the command byte.
- The initiator-side FSM imports the same package.
- One sub-module, spi_edge_sync: a SYNC_STAGES synchronizer plus edge detector. It outputs level, rise and fall. It is instantiated three times (SCLK, CS, MOSI); the MOSI instance uses only the level output.

## Test plan
- Write then read back: write 8'hA5 to address 7'h12. Second frame reads 7'h12, and MISO returns 1010_0101 on 8 consecutive rising edges. MISO_OE is high for both frames.
- Reset contents: read address 7'h7F immediately after reset and get 8'h00. MISO and MISO_OE are 0 before the CS falling edge.
- Aborted write: write 8'h3C to 7'h05, then write 8'hFF to 7'h05 with CS raised after 4 data bits. A read of 7'h05 returns 8'h3C.
- Over-clocked frame: write frame to 7'h01 with 8'h11, followed by 8 extra SCLK pulses carrying 8'hEE before CS rises. mem[7'h01] = 8'h11 and MISO stays 0 during the extras.
- Asynchronous reset mid-read:
  - RST_N is pulsed low during bit 3 of an RDATA phase; MISO and MISO_OE drop to 0 immediately.
  - After release, the next full write/read frame pair to 7'h40 with 8'h5A completes correctly.
- Minimum SCLK: the back-to-back write/read of 8'hC3 passes with SCLK high and low phases of 4 CLK each (SYNC_STAGES=2).
